// File: rtl/simd_pkg.sv
// Opcodes, instruction field positions, FSM states and register-select type for the SIMD sequencer.
package simd_pkg;

    localparam int OP_LSB  = 12;
    localparam int SEL_LSB = 10;
    localparam int IMM_W   = 10;

    typedef logic [5:0] opcode_t;

    localparam opcode_t OP_LOOPJUMP = 6'b100100;
    localparam opcode_t OP_SETLOOP  = 6'b100101;
    localparam opcode_t OP_LOAD16   = 6'b100110;
    localparam opcode_t OP_LOAD8    = 6'b100111;
    localparam opcode_t OP_LOAD4    = 6'b101000;
    localparam opcode_t OP_STORE16  = 6'b101001;
    localparam opcode_t OP_STORE8   = 6'b101010;
    localparam opcode_t OP_STORE4   = 6'b101011;
    localparam opcode_t OP_SET16    = 6'b101100;
    localparam opcode_t OP_SET8     = 6'b101101;
    localparam opcode_t OP_SET4     = 6'b101110;
    localparam opcode_t OP_HALT     = 6'b111111;

    typedef logic [1:0] reg_sel_t;
    localparam reg_sel_t SEL_INVALID = 2'b11;

    typedef enum logic [2:0] {
        ST_IF, ST_ID, ST_LD, ST_LDW, ST_ST, ST_EX, ST_HALT
    } state_t;

    typedef enum logic [1:0] {
        LANE_16, LANE_8, LANE_4
    } lane_t;

    function automatic logic is_load(opcode_t op);
        return op inside {OP_LOAD16, OP_LOAD8, OP_LOAD4};
    endfunction

    function automatic logic is_store(opcode_t op);
        return op inside {OP_STORE16, OP_STORE8, OP_STORE4};
    endfunction

    function automatic logic is_set(opcode_t op);
        return op inside {OP_SET16, OP_SET8, OP_SET4};
    endfunction

    function automatic logic is_loop(opcode_t op);
        return op inside {OP_SETLOOP, OP_LOOPJUMP};
    endfunction

endpackage

// File: rtl/simd_lane_rep.sv
// Immediate lane replication for the set instructions: 16-bit zero-extend, 8-bit x2, 4-bit x4.
// Purely combinational, no flow control.
module simd_lane_rep
    import simd_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [IMM_W-1:0]  imm,
    input  lane_t             mode,
    output logic [DATA_W-1:0] value
);

    localparam int R8 = (DATA_W + 7) / 8;
    localparam int R4 = (DATA_W + 3) / 4;

    logic [R8*8-1:0] rep8;
    logic [R4*4-1:0] rep4;

    assign rep8 = {R8{imm[7:0]}};
    assign rep4 = {R4{imm[3:0]}};

    always_comb begin
        case (mode)
            LANE_8:  value = rep8[DATA_W-1:0];
            LANE_4:  value = rep4[DATA_W-1:0];
            default: value = DATA_W'(imm);
        endcase
    end

endmodule

// File: rtl/simd_mem_sequencer.sv
// SIMD memory sequencer: fetch/decode, loads, stores and sets run locally; other opcodes go to the ALU.
// Latency: set/loop 2 cycles, store 3, load 4, exec 3 plus ready wait. Loops need SIMD_LOOP_EN.
// Backpressure: only exec_ready stalls the sequencer (PC frozen in EX until it is sampled high).
module simd_mem_sequencer
    import simd_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int INST_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] instruction_addr,
    input  logic [INST_W-1:0] instruction_in,
    output logic [ADDR_W-1:0] data_addr,
    output logic              data_R,
    output logic              data_W,
    output logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] data_in,
    output logic              exec_valid,
    output logic [INST_W-1:0] exec_inst,
    input  logic              exec_ready,
    input  logic              wb_valid,
    input  logic [1:0]        wb_sel,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] rf0,
    output logic [DATA_W-1:0] rf1,
    output logic [DATA_W-1:0] rf2,
    output logic              done,
    output logic              err
);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] ir;
    logic [DATA_W-1:0] rf [3];
`ifdef SIMD_LOOP_EN
    logic [IMM_W-1:0]  lc;
`endif

    opcode_t           op_id;
    reg_sel_t          sel_id, sel_ir;
    logic [IMM_W-1:0]  imm_id, imm_ir;
    logic              sel_bad_id;
    lane_t             lane_mode;
    logic [DATA_W-1:0] set_value, st_value;

    // ID decodes straight from the fetch bus; later states work from the latched IR.
    assign op_id      = instruction_in[OP_LSB +: 6];
    assign sel_id     = instruction_in[SEL_LSB +: 2];
    assign imm_id     = instruction_in[IMM_W-1:0];
    assign sel_ir     = ir[SEL_LSB +: 2];
    assign imm_ir     = ir[IMM_W-1:0];
    assign sel_bad_id = (sel_id == SEL_INVALID);

    always_comb begin
        case (op_id)
            OP_SET8: lane_mode = LANE_8;
            OP_SET4: lane_mode = LANE_4;
            default: lane_mode = LANE_16;
        endcase
    end

    simd_lane_rep #(.DATA_W(DATA_W)) u_lane_rep (
        .imm   (imm_id),
        .mode  (lane_mode),
        .value (set_value)
    );

    always_comb begin
        case (sel_ir)
            2'd0:    st_value = rf[0];
            2'd1:    st_value = rf[1];
            2'd2:    st_value = rf[2];
            default: st_value = '0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IF: state_nx = ST_ID;
            ST_ID: begin
                if (op_id == OP_HALT)                        state_nx = ST_HALT;
                else if (is_load(op_id) && !sel_bad_id)      state_nx = ST_LD;
                else if (is_store(op_id) && !sel_bad_id)     state_nx = ST_ST;
                else if (is_load(op_id) || is_store(op_id) ||
                         is_set(op_id) || is_loop(op_id))    state_nx = ST_IF;
                else                                         state_nx = ST_EX;
            end
            ST_LD:   state_nx = ST_LDW;
            ST_LDW:  state_nx = ST_IF;
            ST_ST:   state_nx = ST_IF;
            ST_EX:   if (exec_ready) state_nx = ST_IF;
            ST_HALT: state_nx = ST_HALT;
            default: state_nx = ST_IF;
        endcase
    end

    always_comb begin
        data_R     = 1'b0;
        data_W     = 1'b0;
        data_addr  = '0;
        data_out   = '0;
        exec_valid = 1'b0;
        exec_inst  = '0;
        done       = 1'b0;
        case (state)
            ST_LD: begin
                data_R    = 1'b1;
                data_addr = ADDR_W'(imm_ir);
            end
            ST_ST: begin
                data_R    = 1'b1;
                data_W    = 1'b1;
                data_addr = ADDR_W'(imm_ir);
                data_out  = st_value;
            end
            ST_EX: begin
                exec_valid = 1'b1;
                exec_inst  = ir;
            end
            ST_HALT: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IF;
            pc    <= '0;
            ir    <= '0;
            rf    <= '{default: '0};
            err   <= 1'b0;
`ifdef SIMD_LOOP_EN
            lc    <= '0;
`endif
        end else begin
            state <= state_nx;
            // ALU writeback goes first so a same-cycle sequencer write to the same register overrides it.
            if (wb_valid) begin
                if (wb_sel == SEL_INVALID) err <= 1'b1;
                else                       rf[wb_sel] <= wb_data;
            end
            case (state)
                ST_ID: begin
                    ir <= instruction_in;
                    if (is_set(op_id) || is_load(op_id) || is_store(op_id)) begin
                        if (sel_bad_id) begin
                            err <= 1'b1;
                            pc  <= pc + 1'b1;
                        end else if (is_set(op_id)) begin
                            rf[sel_id] <= set_value;
                            pc         <= pc + 1'b1;
                        end
                    end
                    if (is_loop(op_id)) begin
`ifdef SIMD_LOOP_EN
                        if (op_id == OP_SETLOOP) begin
                            lc <= imm_id;
                            pc <= pc + 1'b1;
                        end else if (lc != '0) begin
                            lc <= lc - 1'b1;
                            pc <= ADDR_W'(imm_id);
                        end else begin
                            pc <= pc + 1'b1;
                        end
`else
                        err <= 1'b1;
                        pc  <= pc + 1'b1;
`endif
                    end
                end
                ST_LDW: begin
                    rf[sel_ir] <= data_in;
                    pc         <= pc + 1'b1;
                end
                ST_ST:   pc <= pc + 1'b1;
                ST_EX:   if (exec_ready) pc <= pc + 1'b1;
                default: ;
            endcase
        end
    end

    assign instruction_addr = pc;
    assign rf0 = rf[0];
    assign rf1 = rf[1];
    assign rf2 = rf[2];

endmodule

// File: tb/tb_simd_mem_sequencer.sv
// Bench for simd_mem_sequencer: directed scenarios plus random programs checked against an instruction-level model.
module tb_simd_mem_sequencer;
    import simd_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int INST_W = 18;
    localparam int MEM_N  = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] instruction_addr;
    logic [INST_W-1:0] instruction_in;
    logic [ADDR_W-1:0] data_addr;
    logic              data_R, data_W;
    logic [DATA_W-1:0] data_out, data_in;
    logic              exec_valid, exec_ready;
    logic [INST_W-1:0] exec_inst;
    logic              wb_valid;
    logic [1:0]        wb_sel;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] rf0, rf1, rf2;
    logic              done, err;

    always #5 clk = ~clk;

    simd_mem_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INST_W(INST_W)) dut (
        .clk(clk), .rst(rst),
        .instruction_addr(instruction_addr), .instruction_in(instruction_in),
        .data_addr(data_addr), .data_R(data_R), .data_W(data_W),
        .data_out(data_out), .data_in(data_in),
        .exec_valid(exec_valid), .exec_inst(exec_inst), .exec_ready(exec_ready),
        .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_data(wb_data),
        .rf0(rf0), .rf1(rf1), .rf2(rf2), .done(done), .err(err)
    );

    logic [INST_W-1:0] imem [MEM_N];
    logic [DATA_W-1:0] dmem [MEM_N];

    always @(posedge clk) instruction_in <= imem[instruction_addr];
    always @(posedge clk) begin
        if (data_R) begin
            if (data_W) dmem[data_addr] <= data_out;
            else        data_in <= dmem[data_addr];
        end
    end

    // Instruction-level reference state
    int                m_pc, m_lc, m_err, body_cnt;
    logic [DATA_W-1:0] m_rf [3];
    logic [DATA_W-1:0] mem_ref [MEM_N];

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [INST_W-1:0] mk(input logic [5:0] op, input int sel, input int imm);
        return {op, 2'(sel), 10'(imm)};
    endfunction

    function automatic logic [DATA_W-1:0] set_val(input logic [5:0] op, input int imm);
        case (op)
            OP_SET8: return 16'((imm % 256) * 257);
            OP_SET4: return 16'((imm % 16) * 'h1111);
            default: return 16'(imm);
        endcase
    endfunction

    function automatic logic [INST_W-1:0] rand_inst(input bit sets_only);
        int k, sel, imm;
        logic [5:0] op;
        k   = sets_only ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 9));
        sel = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
        imm = int'($urandom_range(0, MEM_N - 1));
        case (k)
            0, 1, 2: op = OP_SET16 + 6'($urandom_range(0, 2));
            3:       op = OP_LOAD16 + 6'($urandom_range(0, 2));
            4:       op = OP_STORE16 + 6'($urandom_range(0, 2));
            5: begin
                op  = OP_SETLOOP;
                imm = int'($urandom_range(0, 3));
            end
            6:       op = OP_LOOPJUMP;
            default: op = 6'($urandom_range(0, 35));
        endcase
        return mk(op, sel, imm);
    endfunction

    task automatic model_reset();
        m_pc  = 0;
        m_lc  = 0;
        m_err = 0;
        m_rf  = '{default: '0};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exec_ready = 1'b0;
        wb_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    // Runs one instruction starting in its IF cycle; an optional writeback lands in IF (0) or ID (1).
    task automatic run_instr(input int wb_cyc, input int wsel, input logic [DATA_W-1:0] wdat, input int wait_cyc);
        logic [INST_W-1:0] inst;
        logic [5:0] op;
        int sel, imm;
        inst = imem[m_pc];
        op   = inst[17:12];
        sel  = int'(inst[11:10]);
        imm  = int'(inst[9:0]);
        check_eq("pc", instruction_addr, m_pc);
        check_eq("rf0", rf0, m_rf[0]);
        check_eq("rf1", rf1, m_rf[1]);
        check_eq("rf2", rf2, m_rf[2]);
        check_eq("err", err, m_err);
        check_eq("if_quiet", {data_R, data_W, exec_valid, done}, 0);
        for (int c = 0; c < 2; c++) begin
            if (c == 1) check_eq("id_quiet", data_R, 0);
            wb_valid = (wb_cyc == c);
            wb_sel   = 2'(wsel);
            wb_data  = wdat;
            tick();
        end
        wb_valid = 1'b0;
        if (wb_cyc >= 0) begin
            if (wsel == 3) m_err = 1;
            else           m_rf[wsel] = wdat;
        end

        if (sel == 3 && op inside {OP_SET16, OP_SET8, OP_SET4, OP_LOAD16, OP_LOAD8, OP_LOAD4,
                                   OP_STORE16, OP_STORE8, OP_STORE4}) begin
            m_err = 1;
            m_pc  = (m_pc + 1) % MEM_N;
        end else if (op inside {OP_SET16, OP_SET8, OP_SET4}) begin
            m_rf[sel] = set_val(op, imm);
            m_pc = (m_pc + 1) % MEM_N;
        end else if (op inside {OP_LOAD16, OP_LOAD8, OP_LOAD4}) begin
            check_eq("ld_strobe", {data_R, data_W}, 2'b10);
            check_eq("ld_addr", data_addr, imm);
            tick();
            check_eq("ldw_quiet", data_R, 0);
            tick();
            m_rf[sel] = mem_ref[imm];
            m_pc = (m_pc + 1) % MEM_N;
        end else if (op inside {OP_STORE16, OP_STORE8, OP_STORE4}) begin
            check_eq("st_strobe", {data_R, data_W}, 2'b11);
            check_eq("st_addr", data_addr, imm);
            check_eq("st_data", data_out, m_rf[sel]);
            mem_ref[imm] = m_rf[sel];
            tick();
            m_pc = (m_pc + 1) % MEM_N;
        end else if (op == OP_SETLOOP || op == OP_LOOPJUMP) begin
`ifdef SIMD_LOOP_EN
            if (op == OP_SETLOOP) begin
                m_lc = imm;
                m_pc = (m_pc + 1) % MEM_N;
            end else if (m_lc > 0) begin
                m_lc--;
                m_pc = imm;
            end else begin
                m_pc = (m_pc + 1) % MEM_N;
            end
`else
            m_err = 1;
            m_pc  = (m_pc + 1) % MEM_N;
`endif
        end else begin
            if (m_pc == 16) body_cnt++;
            for (int i = 0; i <= wait_cyc; i++) begin
                check_eq("ex_valid", exec_valid, 1);
                check_eq("ex_inst", exec_inst, inst);
                check_eq("ex_pc_hold", instruction_addr, m_pc);
                exec_ready = (i == wait_cyc);
                tick();
            end
            exec_ready = 1'b0;
            m_pc = (m_pc + 1) % MEM_N;
        end
    endtask

    task automatic run_rand();
        int wc, ws;
        wc = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 1)) : -1;
        ws = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
        run_instr(wc, ws, 16'($urandom), int'($urandom_range(0, 3)));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        exec_ready = 1'b0;
        wb_valid = 1'b0;
        wb_sel = '0;
        wb_data = '0;
        for (int a = 0; a < MEM_N; a++) begin
            imem[a]    = mk(OP_SET16, 0, 0);
            dmem[a]    = 16'($urandom);
            mem_ref[a] = dmem[a];
        end
        dmem[2]    = 16'h0018;
        mem_ref[2] = 16'h0018;
        tick();
        tick();
        check_eq("rst_pc", instruction_addr, 0);
        check_eq("rst_strobe", {data_R, data_W}, 0);
        check_eq("rst_daddr", data_addr, 0);
        check_eq("rst_dout", data_out, 0);
        check_eq("rst_exec", exec_valid, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_rf0", rf0, 0);
        check_eq("rst_rf1", rf1, 0);
        check_eq("rst_rf2", rf2, 0);
        rst = 1'b0;
        model_reset();

        imem[0]  = mk(OP_SET16, 0, 'h014);
        imem[1]  = mk(OP_LOAD16, 2, 2);
        imem[2]  = mk(OP_SET8, 1, 'h05A);
        imem[3]  = mk(OP_SET4, 2, 'h05A);
        imem[4]  = mk(OP_STORE16, 0, 5);
        imem[5]  = mk(6'b000001, 0, 0);
        for (int a = 6; a < 15; a++) imem[a] = mk(OP_SET16, 1, a);
        imem[15] = mk(OP_SETLOOP, 0, 2);
        imem[16] = mk(6'b000010, 1, 3);
        imem[17] = mk(OP_LOOPJUMP, 0, 16);
        imem[18] = mk(OP_SET16, 2, 'h123);

        run_instr(-1, 0, '0, 0);
        run_instr(-1, 0, '0, 0);
        check_eq("load16_rf2", rf2, 16'h0018);
        run_instr(1, 1, 16'hBEEF, 0);
        check_eq("set8_rf1", rf1, 16'h5A5A);
        run_instr(-1, 0, '0, 0);
        check_eq("set4_rf2", rf2, 16'hAAAA);
        run_instr(-1, 0, '0, 0);
        check_eq("store_mem", dmem[5], 16'h0014);
        run_instr(-1, 0, '0, 3);
        check_eq("exec_pc", instruction_addr, 6);
        body_cnt = 0;
        n = 0;
        while (m_pc != 19 && n < 40) begin
            run_instr(-1, 0, '0, int'($urandom_range(0, 2)));
            n++;
        end
        check_eq("loop_exit_pc", instruction_addr, 19);
`ifdef SIMD_LOOP_EN
        check_eq("loop_body", body_cnt, 3);
`else
        check_eq("loop_body", body_cnt, 1);
        check_eq("loop_err", err, 1);
`endif

        imem[0] = mk(OP_LOAD16, 1, 7);
        do_reset();
        tick();
        tick();
        check_eq("rst_ld_pre", data_R, 1);
        rst = 1'b1;
        tick();
        check_eq("rst_ld_rd", data_R, 0);
        check_eq("rst_ld_pc", instruction_addr, 0);
        check_eq("rst_ld_rf1", rf1, 0);
        rst = 1'b0;

        imem[0] = mk(OP_HALT, 0, 0);
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            check_eq("halt_done", done, 1);
            check_eq("halt_pc", instruction_addr, 0);
            check_eq("halt_quiet", data_R, 0);
            tick();
        end

        for (int a = 0; a < MEM_N; a++) imem[a] = rand_inst(1'b1);
        do_reset();
        for (int k = 0; k < MEM_N + 6; k++) run_rand();
        check_eq("wrap_pc", instruction_addr, 6);

        for (int a = 0; a < MEM_N; a++) imem[a] = rand_inst(1'b0);
        do_reset();
        for (int k = 0; k < 400; k++) run_rand();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/simd_mem_sequencer.md
SIMD_MEM_SEQUENCER -- requirements
Module: simd_mem_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, instruction and data address width.
REQ-002 SHALL have parameter DATA_W, default 16, data word and register width.
REQ-003 SHALL have parameter INST_W, default 18, instruction width.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port instruction_addr, output, ADDR_W: registered fetch address (PC).
REQ-007 SHALL have port instruction_in, input, INST_W: instruction word, valid one cycle after instruction_addr changes.
REQ-008 SHALL have port data_addr, output, ADDR_W: data memory address.
REQ-009 SHALL have port data_R, output, 1: data access strobe.
REQ-010 SHALL have port data_W, output, 1: write qualifier, meaningful only while data_R=1.
REQ-011 SHALL have port data_out, output, DATA_W: store data.
REQ-012 SHALL have port data_in, input, DATA_W: load data, valid one cycle after a read strobe.
REQ-013 SHALL have ports exec_valid (output, 1), exec_inst (output, INST_W) and exec_ready (input, 1) for ALU handoff.
REQ-014 SHALL have ports wb_valid (input, 1), wb_sel (input, 2) and wb_data (input, DATA_W) for ALU writeback.
REQ-015 SHALL have ports rf0, rf1 and rf2 (output, DATA_W each), the register file contents.
REQ-016 SHALL have ports done (output, 1) and err (output, 1, sticky).

Function
REQ-017 SHALL sequence states IF -> ID -> {LD -> LDW | ST | EX | IF} and HALT.
- IF: present PC.
- ID: latch instruction_in and dispatch on opcode bits[17:12].
REQ-018 SHALL treat load16/8/4 (100110/100111/101000) as follows.
- LD: data_R=1, data_W=0, data_addr=bits[9:0].
- LDW: write the raw data_in to the register selected by bits[11:10].
REQ-019 SHALL treat store16/8/4 (101001/101010/101011) as follows.
- ST: data_R=1, data_W=1, data_addr=bits[9:0], data_out=selected register, all for exactly one cycle.
REQ-020 SHALL implement set16 (101100) as reg=zero-extended bits[9:0].
- set8 (101101): bits[7:0] replicated x2.
- set4 (101110): bits[3:0] replicated x4.
- All sets complete in ID.
REQ-021 SHALL implement setloop (100101) as LC=bits[9:0].
- loopjump (100100): if LC!=0, LC-=1 and PC=bits[9:0]; else PC+1.
REQ-022 SHALL handle halt (111111) by entering HALT: done=1, no further fetch; only rst exits.
REQ-023 SHALL handle any other opcode by driving exec_valid=1 with exec_inst=IR in EX until sampled exec_ready=1, then going to IF with PC+1.
REQ-024 SHALL apply wb_valid=1 in any state as rf[wb_sel]<=wb_data.
- If it coincides with an LDW/set write to the same register, the sequencer's own write wins.
REQ-025 SHALL treat a register select of 2'b11, or wb_sel=3, as a NOP and set err=1.
REQ-026 SHALL wrap PC from 2^ADDR_W-1 to 0.
REQ-027 SHALL hold data_R=0 in every state except LD and ST; data_W=0 whenever data_R=0.
REQ-028 SHALL give latencies of 2 cycles for set/setloop/loopjump, 4 for load, 3 for store, and 3 plus ready wait for exec.

Reset
REQ-029 SHALL on rst=1 set the following, overriding any in-flight access or exec handshake:
- state=IF, PC=0, LC=0
- rf0..rf2=0, IR=0
- data_R=0, data_W=0, data_addr=0, data_out=0
- exec_valid=0, done=0, err=0

Configuration
REQ-030 SHALL, with SIMD_LOOP_EN defined, implement setloop/loopjump per REQ-021.
REQ-031 SHALL, without SIMD_LOOP_EN, omit LC, execute setloop/loopjump as NOPs (PC+1) and set err=1.

Structure
REQ-032 SHALL place the opcode constants, the state enum and the register-select type in package simd_pkg.
REQ-033 SHALL contain one sub-module, simd_lane_rep: the combinational 16/8/4 lane replication used by set.

Verification
REQ-034 SHALL cover: MEM[2]=0x0018; load16 R2 im=2 -> data_R pulse with addr 2, then rf2=0x0018.
REQ-035 SHALL cover: set8 R1 im=0x05A -> rf1=0x5A5A; set4 R2 im=0x05A -> rf2=0xAAAA.
REQ-036 SHALL cover: rf0=0x0014, store16 R0 im=5 -> one cycle of data_R=1, data_W=1, addr 5, data_out=0x0014.
REQ-037 SHALL cover: setloop 2, body, loopjump 16 -> body executes 3 times, then PC proceeds past loopjump.
REQ-038 SHALL cover: add opcode with exec_ready held 0 for 3 cycles -> exec_valid stays 1 and PC frozen, then PC+1.
REQ-039 SHALL cover: rst asserted during LD -> next cycle data_R=0, PC=0; halt -> done=1 and instruction_addr stable.
